// File: rtl/gray_step_monitor.sv
// Resynchronises a Gray-coded counter bus, decodes it to binary and classifies each
// cycle-to-cycle change as hold, step up, step down or illegal jump, with error tracking.
module gray_step_monitor #(
    parameter int WIDTH       = 3,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     gray_in,
    input  logic                 clr_err,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 valid,
    output logic                 step_up,
    output logic                 step_dn,
    output logic                 wrap,
    output logic                 err,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int FILL_W = (SYNC_STAGES < 1) ? 1 : $clog2(SYNC_STAGES + 1);
    localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(SYNC_STAGES);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r;
    logic [FILL_W-1:0]                 fill_r;
    logic [WIDTH-1:0]                  new_bin_s;
    logic [WIDTH-1:0]                  delta_s;
    logic                              up_s;
    logic                              dn_s;
    logic                              wrap_s;
    logic                              err_s;
    logic                              sticky_next_s;
    logic [ERR_CNT_W-1:0]              cnt_next_s;

    // Bit i of the binary value is the XOR of all Gray bits at or above i.
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = '0;
        for (int i = 0; i < WIDTH; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    // Input synchroniser chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_r <= '0;
        end else begin
            sync_r[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    // Classify the modular difference between the incoming and currently held value.
    always_comb begin
        new_bin_s = gray2bin(sync_r[SYNC_STAGES-1]);
        delta_s   = new_bin_s - bin_out;
        up_s      = 1'b0;
        dn_s      = 1'b0;
        wrap_s    = 1'b0;
        err_s     = 1'b0;
        if (!valid) begin
            up_s = 1'b0;
        end else if (delta_s == WIDTH'(0)) begin
            up_s = 1'b0;
        end else if (delta_s == WIDTH'(1)) begin
            // Checked before step-down so that WIDTH=1 treats every toggle as a step up.
            up_s   = 1'b1;
            wrap_s = (bin_out == {WIDTH{1'b1}});
        end else if (delta_s == {WIDTH{1'b1}}) begin
            dn_s = 1'b1;
        end else begin
            err_s = 1'b1;
        end
    end

    // Error bookkeeping; a simultaneous error wins over the clear and counts as the first.
    always_comb begin
        sticky_next_s = err_sticky;
        cnt_next_s    = err_cnt;
        case ({clr_err, err_s})
            2'b11: begin
                sticky_next_s = 1'b1;
                cnt_next_s    = ERR_CNT_W'(1);
            end
            2'b10: begin
                sticky_next_s = 1'b0;
                cnt_next_s    = '0;
            end
            2'b01: begin
                sticky_next_s = 1'b1;
                cnt_next_s    = (&err_cnt) ? err_cnt : err_cnt + ERR_CNT_W'(1);
            end
            default: begin
                sticky_next_s = err_sticky;
                cnt_next_s    = err_cnt;
            end
        endcase
    end

    // Output registers and pipeline fill tracking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_r     <= '0;
            bin_out    <= '0;
            valid      <= 1'b0;
            step_up    <= 1'b0;
            step_dn    <= 1'b0;
            wrap       <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else begin
            fill_r     <= (fill_r == FILL_DONE) ? fill_r : fill_r + FILL_W'(1);
            bin_out    <= new_bin_s;
            valid      <= (fill_r == FILL_DONE);
            step_up    <= up_s;
            step_dn    <= dn_s;
            wrap       <= wrap_s;
            err        <= err_s;
            err_sticky <= sticky_next_s;
            err_cnt    <= cnt_next_s;
        end
    end

endmodule
